// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR period monitor and its benches.
package lfsr_pkg;

  // Measurement FSM states.
  typedef enum logic [2:0] {
    IDLE,
    ARM,
    COUNT,
    DONE,
    FAULT
  } mon_state_e;

  // Default LFSR state width.
  localparam int unsigned LFSR_WIDTH = 16;

  // Period of a maximal-length LFSR of the default width.
  localparam int unsigned LFSR_MAX_PERIOD = (2 ** LFSR_WIDTH) - 1;

endpackage

// File: rtl/lfsr_period_monitor.sv
// Measures the recurrence period of an LFSR state stream and flags lock-up,
// frozen-state and no-recurrence faults.
module lfsr_period_monitor
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = LFSR_WIDTH,
  parameter int unsigned CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             state_valid,
  input  logic [WIDTH-1:0] state_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic             stuck_zero,
  output logic             stuck_hold,
  output logic             timeout
);

  // Sample count at which no recurrence means a fault (2^WIDTH).
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(1) << WIDTH;

  mon_state_e       state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             hold_q, hold_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_next;

  assign cnt_next = cnt_q + CNT_W'(1);

  // State and result registers; reset aborts any measurement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ref_q    <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      hold_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      hold_q   <= hold_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state logic: capture reference, count, and classify each valid sample.
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    done_d   = done_q;
    zero_d   = zero_q;
    hold_d   = hold_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      IDLE, DONE, FAULT: begin
        if (start) begin
          state_d  = ARM;
          period_d = '0;
          done_d   = 1'b0;
          zero_d   = 1'b0;
          hold_d   = 1'b0;
          tmo_d    = 1'b0;
        end
      end
      ARM: begin
        if (state_valid) begin
          ref_d  = state_in;
          prev_d = state_in;
          cnt_d  = '0;
          if (state_in == '0) begin
            zero_d  = 1'b1;
            state_d = FAULT;
          end else begin
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        if (state_valid) begin
          if (state_in == '0) begin
            zero_d  = 1'b1;
            state_d = FAULT;
          end else if (state_in == prev_q) begin
            hold_d  = 1'b1;
            state_d = FAULT;
          end else if (state_in == ref_q) begin
            period_d = cnt_next;
            done_d   = 1'b1;
            state_d  = DONE;
          end else if (cnt_next == CNT_LIMIT) begin
            tmo_d   = 1'b1;
            state_d = FAULT;
          end else begin
            cnt_d  = cnt_next;
            prev_d = state_in;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == ARM) || (state_q == COUNT);
  assign done       = done_q;
  assign period     = period_q;
  assign stuck_zero = zero_q;
  assign stuck_hold = hold_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Self-checking bench for lfsr_period_monitor: a 16-bit default instance and
// a 4-bit instance, driven from sample lists checked against a list-scanning model.
module tb_lfsr_period_monitor;
  import lfsr_pkg::*;

  typedef enum int {K_NONE, K_DONE, K_ZERO, K_HOLD, K_TMO} kind_e;

  logic        clk = 1'b0;
  logic        reset;
  logic        s16_start, s16_valid;
  logic [15:0] s16_in;
  logic        b16, d16, z16, h16, t16;
  logic [16:0] p16;
  logic        s4_start, s4_valid;
  logic [3:0]  s4_in;
  logic        b4, d4, z4, h4, t4;
  logic [4:0]  p4;

  logic [15:0] stim[$];
  int checks = 0;
  int errors = 0;

  lfsr_period_monitor dut16 (
    .clk(clk), .reset(reset), .start(s16_start), .state_valid(s16_valid),
    .state_in(s16_in), .busy(b16), .done(d16), .period(p16),
    .stuck_zero(z16), .stuck_hold(h16), .timeout(t16)
  );

  lfsr_period_monitor #(.WIDTH(4), .CNT_W(5)) dut4 (
    .clk(clk), .reset(reset), .start(s4_start), .state_valid(s4_valid),
    .state_in(s4_in), .busy(b4), .done(d4), .period(p4),
    .stuck_zero(z4), .stuck_hold(h4), .timeout(t4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] step4(input logic [15:0] s);
    return {12'h000, s[2:0], s[3] ^ s[2]};
  endfunction

  function automatic logic [15:0] step8(input logic [15:0] s);
    return {8'h00, s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [15:0] step16(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Reference model: scan the valid-sample list; sample 0 is the reference,
  // sample i (i>=1) is the i-th counted sample.
  function automatic void model(input int w, output kind_e k, output int per, output int idx);
    logic [15:0] r, p, s;
    k = K_NONE; per = 0; idx = -1; r = '0; p = '0;
    for (int i = 0; i < stim.size(); i++) begin
      s = stim[i];
      if (i == 0) begin
        if (s == 0) begin k = K_ZERO; idx = 0; return; end
        r = s; p = s;
      end else begin
        if (s == 0)             begin k = K_ZERO; idx = i; return; end
        if (s == p)             begin k = K_HOLD; idx = i; return; end
        if (s == r)             begin k = K_DONE; idx = i; per = i; return; end
        if (i == (1 << w))      begin k = K_TMO;  idx = i; return; end
        p = s;
      end
    end
  endfunction

  task automatic drive(input bit sel, input bit st, input bit v, input logic [15:0] d);
    if (sel) begin s4_start = st; s4_valid = v; s4_in = d[3:0]; end
    else begin s16_start = st; s16_valid = v; s16_in = d; end
  endtask

  // obs = {busy, done, stuck_zero, stuck_hold, timeout}
  task automatic get_obs(input bit sel, output logic [4:0] obs, output int per);
    if (sel) begin obs = {b4, d4, z4, h4, t4}; per = int'(p4); end
    else begin obs = {b16, d16, z16, h16, t16}; per = int'(p16); end
  endtask

  task automatic run_measure(input string name, input bit sel, input int gap_pct, input bit noise);
    kind_e k;
    int per, idx, last, g, oper;
    logic [4:0] obs, exp_obs;
    logic [15:0] mask;
    mask = sel ? 16'h000f : 16'hffff;
    model(sel ? 4 : 16, k, per, idx);
    // start pulse, possibly together with a sample that must not be captured
    @(negedge clk);
    drive(sel, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom) & mask);
    @(posedge clk); #1;
    get_obs(sel, obs, oper);
    checks++;
    if (obs !== 5'b10000 || oper !== 0) begin
      errors++;
      $display("FAIL %s_start: flags=%b period=%0d expected flags=10000 period=0", name, obs, oper);
    end
    last = (k == K_NONE) ? stim.size() - 1 : idx;
    for (int i = 0; i <= last; i++) begin
      g = 0;
      while (g < 3 && $urandom_range(0, 99) < gap_pct) begin
        @(negedge clk);
        drive(sel, noise && ($urandom_range(0, 3) == 0), 1'b0, 16'($urandom) & mask);
        g++;
      end
      @(negedge clk);
      drive(sel, noise && ($urandom_range(0, 3) == 0), 1'b1, stim[i]);
      @(posedge clk); #1;
      get_obs(sel, obs, oper);
      if (i < last || k == K_NONE) begin
        checks++;
        if (obs !== 5'b10000 || oper !== 0) begin
          errors++;
          $display("FAIL %s_busy[%0d]: flags=%b period=%0d expected flags=10000 period=0", name, i, obs, oper);
        end
      end
    end
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, '0);
    if (k == K_NONE) begin
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      return;
    end
    exp_obs = {1'b0, k == K_DONE, k == K_ZERO, k == K_HOLD, k == K_TMO};
    get_obs(sel, obs, oper);
    checks++;
    if (obs !== exp_obs) begin
      errors++;
      $display("FAIL %s_flags: got %b expected %b", name, obs, exp_obs);
    end
    checks++;
    if (oper !== per) begin
      errors++;
      $display("FAIL %s_period: got %0d expected %0d", name, oper, per);
    end
    // results hold while further samples arrive without a start
    repeat (2) begin
      @(negedge clk);
      drive(sel, 1'b0, 1'b1, 16'($urandom) & mask);
    end
    @(posedge clk); #1;
    get_obs(sel, obs, oper);
    checks++;
    if (obs !== exp_obs || oper !== per) begin
      errors++;
      $display("FAIL %s_hold: flags=%b period=%0d expected flags=%b period=%0d", name, obs, oper, exp_obs, per);
    end
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, '0);
  endtask

  task automatic load_lfsr4();
    logic [15:0] s = 16'h0001;
    stim.delete();
    for (int i = 0; i < 16; i++) begin stim.push_back(s); s = step4(s); end
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    int oper;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      get_obs(s[0], obs, oper);
      checks++;
      if (obs !== 5'b00000 || oper !== 0) begin
        errors++;
        $display("FAIL reset_%0d: flags=%b period=%0d expected flags=00000 period=0", s, obs, oper);
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_period4();
    load_lfsr4();
    run_measure("period4", 1'b1, 0, 1'b0);
  endtask

  task automatic test_period_gaps();
    load_lfsr4();
    run_measure("period_gaps", 1'b0, 50, 1'b0);
  endtask

  task automatic test_period8_noise();
    logic [15:0] s = 16'h0001;
    stim.delete();
    for (int i = 0; i < 257; i++) begin stim.push_back(s); s = step8(s); end
    run_measure("period8", 1'b0, 30, 1'b1);
  endtask

  task automatic test_hold();
    stim = '{16'd13, 16'd13, 16'd13};
    run_measure("hold", 1'b0, 0, 1'b0);
  endtask

  task automatic test_zero();
    logic [15:0] s = 16'd13;
    stim.delete();
    for (int i = 0; i < 6; i++) begin stim.push_back(s); s = step16(s); end
    stim.push_back(16'd0);
    stim.push_back(16'd7);
    run_measure("zero", 1'b0, 20, 1'b0);
  endtask

  task automatic test_zero_ref();
    stim = '{16'd0, 16'd5, 16'd6};
    run_measure("zero_ref", 1'b0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    stim.delete();
    stim.push_back(16'h1);
    for (int i = 0; i < 16; i++) stim.push_back(16'(2 + (i % 3)));
    run_measure("timeout", 1'b1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    load_lfsr4();
    run_measure("b2b_a", 1'b1, 40, 1'b1);
    run_measure("b2b_b", 1'b1, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs;
    int oper;
    load_lfsr4();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, stim[i]);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    get_obs(1'b0, obs, oper);
    checks++;
    if (obs !== 5'b00000 || oper !== 0) begin
      errors++;
      $display("FAIL reset_mid: flags=%b period=%0d expected flags=00000 period=0", obs, oper);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0);
    reset = 1'b1;
    run_measure("after_reset", 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    bit sel;
    for (int r = 0; r < 8; r++) begin
      sel = 1'($urandom_range(0, 1));
      stim.delete();
      for (int i = 0; i < 25; i++)
        stim.push_back(($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 5)));
      run_measure($sformatf("random%0d", r), sel, 25, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_period4();
    test_period_gaps();
    test_period8_noise();
    test_hold();
    test_zero();
    test_zero_ref();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
